// File: rtl/pwr_event_arbiter_pkg.sv
// Shared power-sequencer definitions: default timing constants and a width helper.
package pwr_event_arbiter_pkg;

    localparam int PWRSEQ_TICK_DIV  = 1000;
    localparam int PWRSEQ_DEB_TICKS = 4;

    // Never returns less than 1 so single-state counters still get a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pwr_event_arbiter_edge_detect.sv
// Per-bit rising/falling edge detector; tick gates when the delayed copy updates.
module edge_detect #(
    parameter int                SIGCNT   = 8,
    parameter logic [SIGCNT-1:0] DEF_INIT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [SIGCNT-1:0] din,
    output logic [SIGCNT-1:0] rising,
    output logic [SIGCNT-1:0] falling
);

    logic [SIGCNT-1:0] din_d_q;
    logic [SIGCNT-1:0] din_d_d;

    always_comb begin
        din_d_d = din_d_q;
        if (tick) begin
            din_d_d = din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_d_q <= DEF_INIT;
        end else begin
            din_d_q <= din_d_d;
        end
    end

    assign rising  = din & ~din_d_q;
    assign falling = ~din & din_d_q;

endmodule

// File: rtl/pwr_event_arbiter.sv
// Debounces asynchronous power-good/button levels and serialises their edges
// into a round-robin valid/ready event stream with sticky overflow flags.
module pwr_event_arbiter
    import pwr_event_arbiter_pkg::*;
#(
    parameter int                SIGCNT    = 8,
    parameter logic [SIGCNT-1:0] DEF_INIT  = '0,
    parameter int                TICK_DIV  = PWRSEQ_TICK_DIV,
    parameter int                DEB_TICKS = PWRSEQ_DEB_TICKS,
    localparam int               CW        = clog2(SIGCNT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [SIGCNT-1:0] sig_in,
    output logic [SIGCNT-1:0] filt_out,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CW-1:0]     evt_chan,
    output logic              evt_rise,
    output logic [SIGCNT-1:0] ovf,
    input  logic [SIGCNT-1:0] ovf_clr
);

    localparam int TW = clog2(TICK_DIV);
    localparam int DW = clog2(DEB_TICKS);

    logic [SIGCNT-1:0] sync1_q, sync2_q;
    logic [SIGCNT-1:0] filt_q, filt_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [SIGCNT-1:0] pend_q, pend_d;
    logic [SIGCNT-1:0] lvl_q, lvl_d;
    logic [SIGCNT-1:0] ovf_q, ovf_d, ovf_set;
    logic              evt_valid_q, evt_valid_d;
    logic [CW-1:0]     evt_chan_q, evt_chan_d;
    logic              evt_rise_q, evt_rise_d;
    logic [CW-1:0]     last_grant_q, last_grant_d;
    logic [SIGCNT-1:0] rising, falling, edge_any;
    logic              edge_rst;
    logic              out_free;
    logic              grant_vld;
    logic [CW-1:0]     grant_idx;
    logic              found_hi, found_lo;
    logic [CW-1:0]     hi_idx, lo_idx;

    always_comb begin
        tick       = 1'b0;
        tick_cnt_d = '0;
        if (enable) begin
            if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
                tick = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SIGCNT; gi++) begin : g_deb
            logic [DW-1:0] cnt_q, cnt_d;
            logic          filt_bit_d;

            // A channel only advances while it disagrees with its filtered level.
            always_comb begin
                cnt_d      = cnt_q;
                filt_bit_d = filt_q[gi];
                if (!enable || (sync2_q[gi] == filt_q[gi])) begin
                    cnt_d = '0;
                end else if (tick) begin
                    if (cnt_q == DW'(DEB_TICKS - 1)) begin
                        cnt_d      = '0;
                        filt_bit_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign filt_d[gi] = filt_bit_d;
        end
    endgenerate

    assign edge_rst = ~reset_n;

    edge_detect #(
        .SIGCNT   (SIGCNT),
        .DEF_INIT (DEF_INIT)
    ) u_edge (
        .clk     (clk),
        .reset   (edge_rst),
        .tick    (1'b1),
        .din     (filt_q),
        .rising  (rising),
        .falling (falling)
    );

    assign edge_any = rising | falling;
    assign out_free = !evt_valid_q || evt_ready;

    // Descending scan leaves the lowest index above and at-or-below last_grant.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = SIGCNT - 1; i >= 0; i--) begin
            if (pend_q[i] && (CW'(i) > last_grant_q)) begin
                found_hi = 1'b1;
                hi_idx   = CW'(i);
            end
            if (pend_q[i] && (CW'(i) <= last_grant_q)) begin
                found_lo = 1'b1;
                lo_idx   = CW'(i);
            end
        end
        grant_vld = out_free && (found_hi || found_lo);
        grant_idx = found_hi ? hi_idx : lo_idx;
    end

    generate
        for (gi = 0; gi < SIGCNT; gi++) begin : g_pend
            logic load;

            assign load = grant_vld && (grant_idx == CW'(gi));

            // A same-cycle edge wins over the load, so the new level stays queued.
            always_comb begin
                pend_d[gi]  = pend_q[gi] & ~load;
                lvl_d[gi]   = lvl_q[gi];
                ovf_set[gi] = 1'b0;
                if (edge_any[gi]) begin
                    pend_d[gi]  = 1'b1;
                    lvl_d[gi]   = filt_q[gi];
                    ovf_set[gi] = pend_q[gi] & ~load;
                end
            end
        end
    endgenerate

    assign ovf_d = (ovf_q & ~ovf_clr) | ovf_set;

    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_chan_d   = evt_chan_q;
        evt_rise_d   = evt_rise_q;
        last_grant_d = last_grant_q;
        if (grant_vld) begin
            evt_valid_d  = 1'b1;
            evt_chan_d   = grant_idx;
            evt_rise_d   = lvl_q[grant_idx];
            last_grant_d = grant_idx;
        end else if (evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= DEF_INIT;
            sync2_q      <= DEF_INIT;
            filt_q       <= DEF_INIT;
            tick_cnt_q   <= '0;
            pend_q       <= '0;
            lvl_q        <= '0;
            ovf_q        <= '0;
            evt_valid_q  <= 1'b0;
            evt_chan_q   <= '0;
            evt_rise_q   <= 1'b0;
            last_grant_q <= CW'(SIGCNT - 1);
        end else begin
            sync1_q      <= sig_in;
            sync2_q      <= sync1_q;
            filt_q       <= filt_d;
            tick_cnt_q   <= tick_cnt_d;
            pend_q       <= pend_d;
            lvl_q        <= lvl_d;
            ovf_q        <= ovf_d;
            evt_valid_q  <= evt_valid_d;
            evt_chan_q   <= evt_chan_d;
            evt_rise_q   <= evt_rise_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign filt_out  = filt_q;
    assign evt_valid = evt_valid_q;
    assign evt_chan  = evt_chan_q;
    assign evt_rise  = evt_rise_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pwr_event_arbiter.sv
// Directed bench: 4 channels, tick every 4 clocks, 3 ticks of stability, reset level 4'b0010.
module tb_pwr_event_arbiter;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [3:0] sig_in;
    logic [3:0] filt_out;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_chan;
    logic       evt_rise;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int vcount = 0;

    typedef struct {
        int chan;
        int rise;
        int cyc;
    } ev_t;
    ev_t evq[$];

    pwr_event_arbiter #(
        .SIGCNT    (4),
        .DEF_INIT  (4'b0010),
        .TICK_DIV  (4),
        .DEB_TICKS (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .sig_in    (sig_in),
        .filt_out  (filt_out),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_chan  (evt_chan),
        .evt_rise  (evt_rise),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (evt_valid === 1'b1) begin
            vcount <= vcount + 1;
            if (evt_ready === 1'b1) begin
                evq.push_back('{chan: int'(evt_chan), rise: int'(evt_rise), cyc: cyc});
                $display("[TB] accept chan=%0d rise=%0d cycle=%0d", evt_chan, evt_rise, cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_filt(input string tag, input logic [3:0] exp);
        for (int i = 0; i < 60 && filt_out !== exp; i++) begin
            step(1);
        end
        chk(tag, 32'(filt_out), 32'(exp));
    endtask

    task automatic pop_ev(input string tag, input int ch, input int rs, output int c);
        ev_t e;
        c = -1;
        if (evq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed no event expected chan %0d rise %0d", tag, ch, rs);
        end else begin
            e = evq.pop_front();
            chk(tag, 32'(e.chan * 2 + e.rise), 32'(ch * 2 + rs));
            c = e.cyc;
        end
    endtask

    initial begin
        int c1, c2, c3, bad, vsnap;

        reset_n   = 1'b0;
        enable    = 1'b1;
        evt_ready = 1'b1;
        sig_in    = 4'b0010;
        ovf_clr   = 4'b0000;
        step(3);
        chk("reset_filt", 32'(filt_out), 32'h2);
        chk("reset_valid", 32'(evt_valid), 32'h0);
        chk("reset_ovf", 32'(ovf), 32'h0);
        chk("reset_chan_rise", 32'({evt_chan, evt_rise}), 32'h0);
        reset_n = 1'b1;
        step(200);
        chk("idle_filt", 32'(filt_out), 32'h2);
        chk("idle_no_valid", 32'(vcount), 32'h0);

        // Two-tick glitch on ch0 must be rejected.
        sig_in = 4'b0011;
        step(8);
        sig_in = 4'b0010;
        step(40);
        chk("glitch_filt", 32'(filt_out), 32'h2);
        chk("glitch_no_event", 32'(evq.size()), 32'h0);

        sig_in = 4'b0011;
        wait_filt("ch0_rise_filt", 4'b0011);
        step(1);
        chk("ch0_lat_t1", 32'(evt_valid), 32'h0);
        step(1);
        chk("ch0_lat_t2", 32'({evt_valid, evt_chan, evt_rise}), 32'b1_00_1);
        step(20);
        pop_ev("ch0_event", 0, 1, c1);
        chk("ch0_single", 32'(evq.size()), 32'h0);

        // Three simultaneous edges under backpressure.
        evt_ready = 1'b0;
        sig_in = 4'b1101;
        wait_filt("multi_filt", 4'b1101);
        step(2);
        chk("multi_first", 32'({evt_valid, evt_chan, evt_rise}), 32'b1_01_0);
        bad = 0;
        repeat (10) begin
            step(1);
            if (!(evt_valid === 1'b1 && evt_chan === 2'd1 && evt_rise === 1'b0)) bad++;
        end
        chk("stall_stable", 32'(bad), 32'h0);
        evt_ready = 1'b1;
        step(6);
        pop_ev("rr_ch1", 1, 0, c1);
        pop_ev("rr_ch2", 2, 1, c2);
        pop_ev("rr_ch3", 3, 1, c3);
        chk("b2b_12", 32'(c2 - c1), 32'h1);
        chk("b2b_23", 32'(c3 - c2), 32'h1);
        chk("multi_drained", 32'(evt_valid), 32'h0);
        chk("multi_no_ovf", 32'(ovf), 32'h0);

        sig_in = 4'b1001;
        wait_filt("ch2_fall_filt", 4'b1001);
        step(20);
        pop_ev("ch2_fall", 2, 0, c1);

        // ch0 holds the output while ch2 rises then falls.
        evt_ready = 1'b0;
        sig_in = 4'b1000;
        wait_filt("ch0_fall_filt", 4'b1000);
        step(2);
        chk("ch0_hold", 32'({evt_valid, evt_chan, evt_rise}), 32'b1_00_0);
        sig_in = 4'b1100;
        wait_filt("ovf_rise_filt", 4'b1100);
        step(2);
        chk("ovf_not_yet", 32'(ovf), 32'h0);
        sig_in = 4'b1000;
        wait_filt("ovf_fall_filt", 4'b1000);
        step(1);
        chk("ovf_set", 32'(ovf), 32'h4);
        chk("ovf_hold_chan", 32'({evt_valid, evt_chan, evt_rise}), 32'b1_00_0);
        evt_ready = 1'b1;
        step(6);
        pop_ev("ovf_ch0", 0, 0, c1);
        pop_ev("ovf_ch2", 2, 0, c2);
        chk("ovf_single_ch2", 32'(evq.size()), 32'h0);
        ovf_clr = 4'b0100;
        step(1);
        ovf_clr = 4'b0000;
        chk("ovf_cleared", 32'(ovf), 32'h0);

        // Clear pulse coincident with a fresh overflow: set must win.
        evt_ready = 1'b0;
        sig_in = 4'b1001;
        wait_filt("ch0_rise2_filt", 4'b1001);
        step(2);
        chk("ch0_hold2", 32'({evt_valid, evt_chan, evt_rise}), 32'b1_00_1);
        sig_in = 4'b1101;
        wait_filt("ovf2_rise_filt", 4'b1101);
        sig_in = 4'b1001;
        wait_filt("ovf2_fall_filt", 4'b1001);
        ovf_clr = 4'b0100;
        step(1);
        ovf_clr = 4'b0000;
        chk("ovf_set_wins", 32'(ovf), 32'h4);
        step(1);
        chk("ovf_sticky", 32'(ovf), 32'h4);
        evt_ready = 1'b1;
        step(6);
        pop_ev("ovf2_ch0", 0, 1, c1);
        pop_ev("ovf2_ch2", 2, 0, c2);

        // Intake frozen while pending events still drain.
        evt_ready = 1'b0;
        sig_in = 4'b0011;
        wait_filt("freeze_prep_filt", 4'b0011);
        step(2);
        chk("freeze_first", 32'({evt_valid, evt_chan, evt_rise}), 32'b1_11_0);
        enable = 1'b0;
        for (int i = 0; i < 200; i++) begin
            sig_in = 4'($urandom);
            step(1);
        end
        chk("freeze_filt", 32'(filt_out), 32'h3);
        sig_in = 4'b0011;
        evt_ready = 1'b1;
        step(6);
        pop_ev("freeze_ch3", 3, 0, c1);
        pop_ev("freeze_ch1", 1, 1, c2);
        step(5);
        enable = 1'b1;
        step(40);
        chk("reenable_filt", 32'(filt_out), 32'h3);
        chk("reenable_no_event", 32'(evq.size()), 32'h0);

        // Asynchronous reset with an event presented and another pending.
        evt_ready = 1'b0;
        sig_in = 4'b0110;
        wait_filt("rst_prep_filt", 4'b0110);
        step(2);
        chk("rst_prep_evt", 32'({evt_valid, evt_chan, evt_rise}), 32'b1_10_1);
        reset_n = 1'b0;
        sig_in = 4'b0010;
        #2;
        chk("async_valid", 32'(evt_valid), 32'h0);
        chk("async_pend", 32'(dut.pend_q), 32'h0);
        chk("async_filt", 32'(filt_out), 32'h2);
        chk("async_ovf", 32'(ovf), 32'h0);
        vsnap = vcount;
        step(3);
        reset_n = 1'b1;
        evt_ready = 1'b1;
        step(50);
        chk("post_rst_no_valid", 32'(vcount - vsnap), 32'h0);
        chk("post_rst_no_event", 32'(evq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
